// File: rtl/config_pkg.sv
// config_pkg
//   Shared SoC configuration constants and the types used by the boot-ROM
//   arbiter (rom_ahb_arbiter / rom_arb_pick).
//   XLEN         : data-path width in bits.
//   PA_BITS      : physical address width in bits.
//   BOOTROM_BASE : byte address of the first boot-ROM word.
//   rom_arb_port_t, ROM_ARB_PORT0/1 : requester index.
//   HTRANS_IDLE / HTRANS_NONSEQ     : AHB-lite transfer encodings.
package config_pkg;

  localparam int XLEN    = 64;
  localparam int PA_BITS = 32;

  localparam logic [PA_BITS-1:0] BOOTROM_BASE = 32'h0000_1000;

  typedef logic rom_arb_port_t;

  localparam rom_arb_port_t ROM_ARB_PORT0 = 1'b0;
  localparam rom_arb_port_t ROM_ARB_PORT1 = 1'b1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

endpackage

// File: rtl/rom_arb_pick.sv
// rom_arb_pick
//   Combinational winner selection for the two-port boot-ROM arbiter.
//   Ports:
//     req_i       [1:0] : per-port request
//     lock_elig_i [1:0] : port holds a still-valid lock from the previous beat
//     last_gnt_i        : port that won the most recent grant
//     yield_i           : previous grant was locked but its lock budget ran out
//     ready_i           : ROM ready and block out of reset
//     gnt_o       [1:0] : one-hot grant (all zero when nothing is granted)
//   Build option: ROM_ARB_FIXED_PRIO_EN -- ties go to port 0 instead of
//   alternating; locks and the hold budget still apply.
module rom_arb_pick
  import config_pkg::*;
(
  input  logic [1:0]    req_i,
  input  logic [1:0]    lock_elig_i,
  input  rom_arb_port_t last_gnt_i,
  input  logic          yield_i,
  input  logic          ready_i,
  output logic [1:0]    gnt_o
);

  rom_arb_port_t tie_win;

  // When the previous holder exhausted its lock, the waiting peer takes the
  // tie regardless of the base policy, so fixed priority cannot starve port 1.
  always_comb begin
    if (yield_i) begin
      tie_win = ~last_gnt_i;
    end else begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      tie_win = ROM_ARB_PORT0;
`else
      tie_win = ~last_gnt_i;
`endif
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    if (ready_i) begin
      if (req_i[0] && lock_elig_i[0]) begin
        gnt_o = 2'b01;
      end else if (req_i[1] && lock_elig_i[1]) begin
        gnt_o = 2'b10;
      end else if (req_i == 2'b01) begin
        gnt_o = 2'b01;
      end else if (req_i == 2'b10) begin
        gnt_o = 2'b10;
      end else if (req_i == 2'b11) begin
        gnt_o = (tie_win == ROM_ARB_PORT0) ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: rtl/rom_ahb_arbiter.sv
// rom_ahb_arbiter
//   Shares the single-ported boot ROM (AHB-lite slave, registered read data)
//   between two request/grant ports. One address phase per cycle, read data
//   steered back to the issuing port one cycle later.
//   Parameter MAX_HOLD : max consecutive locked grants to one port (>= 1).
//   Ports:
//     HCLK, HRESETn              : clock, async active-low reset
//     Req0/1, Lock0/1, Addr0/1   : requester side inputs
//     Gnt0/1                     : combinational grant
//     RValid0/1, RErr0/1, RData  : read return
//     HSELRom, HADDRRom, HTRANSRom, HREADYToRom : ROM address phase
//     HREADRom, HREADYRom, HRESPRom             : ROM data phase
//   Build option: ROM_ARB_FIXED_PRIO_EN -- fixed priority to port 0 on ties.
module rom_ahb_arbiter
  import config_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               Req0,
  input  logic               Req1,
  input  logic               Lock0,
  input  logic               Lock1,
  input  logic [PA_BITS-1:0] Addr0,
  input  logic [PA_BITS-1:0] Addr1,
  output logic               Gnt0,
  output logic               Gnt1,
  output logic               RValid0,
  output logic               RValid1,
  output logic               RErr0,
  output logic               RErr1,
  output logic [XLEN-1:0]    RData,
  output logic               HSELRom,
  output logic [PA_BITS-1:0] HADDRRom,
  output logic [1:0]         HTRANSRom,
  output logic               HREADYToRom,
  input  logic [XLEN-1:0]    HREADRom,
  input  logic               HREADYRom,
  input  logic               HRESPRom
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  rom_arb_port_t last_gnt_q, last_gnt_d;
  rom_arb_port_t dport_q, dport_d;
  logic          dvalid_q, dvalid_d;
  logic          locked_q, locked_d;   // previous cycle's grant carried Lock=1
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [1:0]    gnt;
  logic [1:0]    lock_elig;
  logic          hold_ok;
  logic          grant_any;
  rom_arb_port_t winner;
  logic          win_lock;

  assign hold_ok      = int'(hold_cnt_q) < (MAX_HOLD - 1);
  assign lock_elig[0] = locked_q && (last_gnt_q == ROM_ARB_PORT0) && hold_ok;
  assign lock_elig[1] = locked_q && (last_gnt_q == ROM_ARB_PORT1) && hold_ok;

  rom_arb_pick u_pick (
    .req_i       ({Req1, Req0}),
    .lock_elig_i (lock_elig),
    .last_gnt_i  (last_gnt_q),
    .yield_i     (locked_q && !hold_ok),
    .ready_i     (HREADYRom && HRESETn),
    .gnt_o       (gnt)
  );

  assign grant_any = |gnt;
  assign winner    = gnt[1] ? ROM_ARB_PORT1 : ROM_ARB_PORT0;
  assign win_lock  = gnt[1] ? Lock1 : Lock0;

  always_comb begin
    last_gnt_d = last_gnt_q;
    dport_d    = dport_q;
    dvalid_d   = dvalid_q;
    locked_d   = 1'b0;
    hold_cnt_d = '0;
    if (grant_any) begin
      last_gnt_d = winner;
      dport_d    = winner;
      dvalid_d   = 1'b1;
      locked_d   = win_lock;
      // Only a win taken through the lock path extends the run.
      if (win_lock && lock_elig[winner]) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end else if (HREADYRom) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_gnt_q <= ROM_ARB_PORT1;
      dport_q    <= ROM_ARB_PORT0;
      dvalid_q   <= 1'b0;
      locked_q   <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      dport_q    <= dport_d;
      dvalid_q   <= dvalid_d;
      locked_q   <= locked_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign Gnt0 = gnt[0];
  assign Gnt1 = gnt[1];

  assign HSELRom     = grant_any;
  assign HTRANSRom   = grant_any ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDRRom    = gnt[0] ? Addr0 : (gnt[1] ? Addr1 : '0);
  assign HREADYToRom = HREADYRom;

  assign RValid0 = dvalid_q && (dport_q == ROM_ARB_PORT0) && HREADYRom;
  assign RValid1 = dvalid_q && (dport_q == ROM_ARB_PORT1) && HREADYRom;
  assign RErr0   = RValid0 && HRESPRom;
  assign RErr1   = RValid1 && HRESPRom;
  assign RData   = HREADRom;

endmodule

// File: tb/tb_rom_ahb_arbiter.sv
module tb_rom_ahb_arbiter;
  import config_pkg::*;

  logic               HCLK = 1'b0;
  logic               HRESETn;
  logic               Req0, Req1, Lock0, Lock1;
  logic [PA_BITS-1:0] Addr0, Addr1;
  logic               Gnt0, Gnt1, RValid0, RValid1, RErr0, RErr1;
  logic [XLEN-1:0]    RData;
  logic               HSELRom, HREADYToRom;
  logic [PA_BITS-1:0] HADDRRom;
  logic [1:0]         HTRANSRom;
  logic [XLEN-1:0]    HREADRom;
  logic               HREADYRom, HRESPRom;

  logic               h1_Gnt0, h1_Gnt1, h1_RValid0, h1_RValid1, h1_RErr0, h1_RErr1;
  logic [XLEN-1:0]    h1_RData;
  logic               h1_HSELRom, h1_HREADYToRom;
  logic [PA_BITS-1:0] h1_HADDRRom;
  logic [1:0]         h1_HTRANSRom;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  rom_ahb_arbiter #(.MAX_HOLD(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .Req0(Req0), .Req1(Req1), .Lock0(Lock0), .Lock1(Lock1),
    .Addr0(Addr0), .Addr1(Addr1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
    .RErr0(RErr0), .RErr1(RErr1), .RData(RData),
    .HSELRom(HSELRom), .HADDRRom(HADDRRom), .HTRANSRom(HTRANSRom),
    .HREADYToRom(HREADYToRom), .HREADRom(HREADRom),
    .HREADYRom(HREADYRom), .HRESPRom(HRESPRom)
  );

  rom_ahb_arbiter #(.MAX_HOLD(1)) dut_h1 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .Req0(Req0), .Req1(Req1), .Lock0(Lock0), .Lock1(Lock1),
    .Addr0(Addr0), .Addr1(Addr1),
    .Gnt0(h1_Gnt0), .Gnt1(h1_Gnt1), .RValid0(h1_RValid0), .RValid1(h1_RValid1),
    .RErr0(h1_RErr0), .RErr1(h1_RErr1), .RData(h1_RData),
    .HSELRom(h1_HSELRom), .HADDRRom(h1_HADDRRom), .HTRANSRom(h1_HTRANSRom),
    .HREADYToRom(h1_HREADYToRom), .HREADRom(HREADRom),
    .HREADYRom(HREADYRom), .HRESPRom(HRESPRom)
  );

  function automatic logic [XLEN-1:0] rom_word(input logic [31:0] idx);
    return {32'hB007_0000, idx};
  endfunction

  // ROM model: registered output, one word per 8 bytes, holds during stalls.
  always_ff @(posedge HCLK) begin
    if (HSELRom && HTRANSRom == HTRANS_NONSEQ && HREADYToRom)
      HREADRom <= rom_word((HADDRRom - BOOTROM_BASE) >> 3);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Req0 = 0; Req1 = 0; Lock0 = 0; Lock1 = 0;
    Addr0 = '0; Addr1 = '0; HREADYRom = 1; HRESPRom = 0;
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 0;
    idle_inputs();
    repeat (2) @(negedge HCLK);
    HRESETn = 1;
  endtask

  logic exp_lock [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  logic exp_w, prev_w;
  logic [31:0] prev_idx;

  initial begin
    HRESETn = 0;
    idle_inputs();
    HREADRom = '0;
    // reset state, with requests asserted to confirm reset gating of grants
    @(negedge HCLK);
    Req0 = 1; Req1 = 1; Addr0 = BOOTROM_BASE + 8;
    #1;
    chk("rst_gnt0", Gnt0, 0);
    chk("rst_gnt1", Gnt1, 0);
    chk("rst_rvalid", {RValid0, RValid1, RErr0, RErr1}, 0);
    chk("rst_hsel", HSELRom, 0);
    chk("rst_htrans", HTRANSRom, HTRANS_IDLE);
    chk("rst_haddr", HADDRRom, 0);

    // single port
    do_reset();
    Req0 = 1; Addr0 = BOOTROM_BASE + 8;
    #1;
    chk("single_gnt0", Gnt0, 1);
    chk("single_gnt1", Gnt1, 0);
    chk("single_haddr", HADDRRom, BOOTROM_BASE + 8);
    chk("single_htrans", HTRANSRom, HTRANS_NONSEQ);
    chk("single_hsel", HSELRom, 1);
    @(negedge HCLK);
    Req0 = 0;
    #1;
    chk("single_rvalid0", RValid0, 1);
    chk("single_rdata", RData, rom_word(1));
    chk("single_rvalid1", RValid1, 0);
    chk("single_idle_haddr", HADDRRom, 0);
    chk("single_idle_htrans", HTRANSRom, HTRANS_IDLE);

    // both ports, no lock
    do_reset();
    prev_w = 0; prev_idx = 0;
    for (int k = 0; k < 6; k++) begin
      Req0 = 1; Req1 = 1;
      Addr0 = BOOTROM_BASE + 32'(16 * k);
      Addr1 = BOOTROM_BASE + 32'(16 * k + 8);
`ifdef ROM_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = logic'(k % 2);
`endif
      #1;
      chk($sformatf("rr_gnt0_%0d", k), Gnt0, !exp_w);
      chk($sformatf("rr_gnt1_%0d", k), Gnt1, exp_w);
      if (k > 0) begin
        chk($sformatf("rr_rvalid0_%0d", k), RValid0, !prev_w);
        chk($sformatf("rr_rvalid1_%0d", k), RValid1, prev_w);
        chk($sformatf("rr_rdata_%0d", k), RData, rom_word(prev_idx));
      end
      prev_w = exp_w;
      prev_idx = 32'(2 * k) + (exp_w ? 32'd1 : 32'd0);
      @(negedge HCLK);
    end
    Req0 = 0; Req1 = 0;
    #1;
    chk("rr_tail_rvalid0", RValid0, !prev_w);
    chk("rr_tail_rvalid1", RValid1, prev_w);
    chk("rr_tail_rdata", RData, rom_word(prev_idx));

    // lock limit (MAX_HOLD=4) and MAX_HOLD=1 boundary on the second instance
    do_reset();
    for (int k = 0; k < 10; k++) begin
      Req0 = 1; Lock0 = 1; Req1 = 1;
      Addr0 = BOOTROM_BASE; Addr1 = BOOTROM_BASE + 8;
      #1;
      chk($sformatf("lock_gnt0_%0d", k), Gnt0, !exp_lock[k]);
      chk($sformatf("lock_gnt1_%0d", k), Gnt1, exp_lock[k]);
      chk($sformatf("hold1_gnt1_%0d", k), h1_Gnt1, logic'(k % 2));
      @(negedge HCLK);
    end

    // ROM stall followed by error response
    do_reset();
    Req1 = 1; Addr1 = BOOTROM_BASE + 32'h18;
    #1;
    chk("stall_gnt1", Gnt1, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      Req1 = 0; Req0 = 1; Addr0 = BOOTROM_BASE + 32'h28; HREADYRom = 0;
      #1;
      chk($sformatf("stall_gnt0_%0d", k), Gnt0, 0);
      chk($sformatf("stall_rvalid1_%0d", k), RValid1, 0);
      chk($sformatf("stall_hsel_%0d", k), HSELRom, 0);
    end
    @(negedge HCLK);
    HREADYRom = 1; HRESPRom = 1;
    #1;
    chk("stall_ret_rvalid1", RValid1, 1);
    chk("stall_ret_rerr1", RErr1, 1);
    chk("stall_ret_rerr0", RErr0, 0);
    chk("stall_ret_rdata", RData, rom_word(3));
    chk("stall_ret_gnt0", Gnt0, 1);
    @(negedge HCLK);
    Req0 = 0; HRESPRom = 0;
    #1;
    chk("stall_next_rvalid0", RValid0, 1);
    chk("stall_next_rerr0", RErr0, 0);
    chk("stall_next_rdata", RData, rom_word(5));

    // reset in the cycle after a grant drops the outstanding beat
    do_reset();
    Req1 = 1; Addr1 = BOOTROM_BASE + 32'h10;
    #1;
    chk("rmid_gnt1", Gnt1, 1);
    @(negedge HCLK);
    HRESETn = 0; Req1 = 0;
    #1;
    chk("rmid_rvalid1_a", RValid1, 0);
    @(negedge HCLK);
    #1;
    chk("rmid_rvalid1_b", RValid1, 0);
    @(negedge HCLK);
    HRESETn = 1; Req0 = 1; Req1 = 1; Addr0 = BOOTROM_BASE; Addr1 = BOOTROM_BASE + 8;
    #1;
    chk("rmid_tie_gnt0", Gnt0, 1);
    chk("rmid_tie_gnt1", Gnt1, 0);
    chk("rmid_rvalid1_c", RValid1, 0);
    @(negedge HCLK);
    Req0 = 0; Req1 = 0;
    #1;
    chk("rmid_rvalid0", RValid0, 1);
    chk("rmid_rvalid1_d", RValid1, 0);
    chk("rmid_rdata", RData, rom_word(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
